// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic cells: FSM encoding,
// legal WIDTH range and a constant clog2 used to size the bit counter.
package arith_pkg;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor: x - y - bi -> difference d, borrow-out bo.
module full_sub (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = x ^ y ^ bi;
   assign bo = (~x & y) | (~x & bi) | (y & bi);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin), LSB first, start/done handshake.
// Optional macro SERIAL_SUB_OVF_EN adds a registered signed-overflow flag on ovf.
module serial_sub
   import arith_pkg::*;
#(
   parameter int WIDTH = 8   // legal range WIDTH_MIN..WIDTH_MAX
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int CW = clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] xa_q, xa_d;
   logic [WIDTH-1:0] xb_q, xb_d;
   logic [WIDTH-2:0] rs_q, rs_d;
   logic             borrow_q, borrow_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;

   logic             d_bit, bo_bit;
   logic [WIDTH-1:0] rs_shift;
   logic             load, fin;

   full_sub u_fs (
      .x  (xa_q[0]),
      .y  (xb_q[0]),
      .bi (borrow_q),
      .d  (d_bit),
      .bo (bo_bit)
   );

   // rs only needs WIDTH-1 bits: the last difference bit goes straight to diff.
   assign rs_shift = {d_bit, rs_q};
   assign load     = start && (state_q != S_RUN);
   assign fin      = (state_q == S_RUN) && (cnt_q == CNT_LAST);

   always_comb begin
      state_d  = state_q;
      xa_d     = xa_q;
      xb_d     = xb_q;
      rs_d     = rs_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      bout_d   = bout_q;

      case (state_q)
         S_IDLE: begin
            if (load) state_d = S_RUN;
         end
         S_RUN: begin
            xa_d     = xa_q >> 1;
            xb_d     = xb_q >> 1;
            rs_d     = rs_shift[WIDTH-1:1];
            borrow_d = bo_bit;
            cnt_d    = cnt_q + 1'b1;
            if (fin) begin
               diff_d  = rs_shift;
               bout_d  = bo_bit;
               cnt_d   = '0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = load ? S_RUN : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (load) begin
         xa_d     = a;
         xb_d     = b;
         rs_d     = '0;
         borrow_d = bin;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         xa_q     <= '0;
         xb_q     <= '0;
         rs_q     <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         xa_q     <= xa_d;
         xb_q     <= xb_d;
         rs_q     <= rs_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
         diff_q   <= diff_d;
         bout_q   <= bout_d;
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   // Sign bits are shifted out of xa/xb during RUN, so keep private copies.
   logic sa_q, sa_d;
   logic sb_q, sb_d;
   logic ovf_q, ovf_d;

   always_comb begin
      sa_d  = sa_q;
      sb_d  = sb_q;
      ovf_d = ovf_q;
      if (load) begin
         sa_d = a[WIDTH-1];
         sb_d = b[WIDTH-1];
      end
      if (fin) ovf_d = (sa_q ^ sb_q) & (d_bit ^ sa_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sa_q  <= 1'b0;
         sb_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         sa_q  <= sa_d;
         sb_q  <= sb_d;
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);
   assign diff = diff_q;
   assign bout = bout_q;

endmodule
